frame_pixel_reader: RTL

Raster pixel source that is the transmit-side counterpart of the frame writer on the CNN accelerator's pixel stream. On a start pulse it reads one frame from a synchronous frame buffer and emits it row by row. Each pixel goes out as a `o_de`/`o_pixel` beat. The block applies a programmable start-up delay before the frame and a horizontal blanking gap after each line. It drives the accelerator's pixel input during simulation and FPGA bring-up.

---
 rtl/frame_pixel_reader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_pixel_reader.sv
// frame_pixel_reader
//
// Raster pixel source. On a start pulse it reads one frame from a synchronous
// frame buffer (one-cycle read latency) and emits it row by row as o_de/o_pixel
// beats. A programmable start-up delay comes before the frame and a horizontal
// blanking gap follows every line except the last.
//
// Optional feature: define FRAME_READER_ABORT_EN to add the i_abort input,
// which drops the frame in progress and returns to IDLE.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   i_start              one-cycle frame request (accepted only in IDLE)
//   i_abort              (FRAME_READER_ABORT_EN only) abandon current frame
//   i_width, i_height    frame geometry, latched at start
//   i_start_up_delay     idle cycles between start and the first read
//   i_hsync_delay        blank cycles after each line except the last
//   o_rd_en, o_rd_addr   frame buffer read port, linear raster address
//   i_rd_data            read data, valid one cycle after o_rd_en
//   o_de, o_pixel        pixel beat
//   o_hsync              high while a line's pixels stream (aligned with o_de)
//   o_vsync              high from the first read until the last o_de
//   o_busy               not IDLE
//   o_frame_done         one-cycle pulse after the last o_de
//   o_dbg_state          current FSM state for observation
//
// Handshake: there is no back-pressure. o_rd_en is a one-cycle request whose
// data the buffer must return on i_rd_data exactly one cycle later; o_de marks
// each valid o_pixel beat and the consumer must take it in that cycle.

module frame_pixel_reader #(
  parameter int W_SIZE  = 12,
  parameter int W_DELAY = 12,
  parameter int W_PIX   = 32,
  parameter int W_ADDR  = 24
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               i_start,
`ifdef FRAME_READER_ABORT_EN
  input  logic               i_abort,
`endif
  input  logic [W_SIZE-1:0]  i_width,
  input  logic [W_SIZE-1:0]  i_height,
  input  logic [W_DELAY-1:0] i_start_up_delay,
  input  logic [W_DELAY-1:0] i_hsync_delay,
  output logic               o_rd_en,
  output logic [W_ADDR-1:0]  o_rd_addr,
  input  logic [W_PIX-1:0]   i_rd_data,
  output logic               o_de,
  output logic [W_PIX-1:0]   o_pixel,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STARTUP = 3'd1,
    S_LINE    = 3'd2,
    S_HBLANK  = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t state, state_d;

  logic [W_SIZE-1:0]  w_q, h_q;
  logic [W_DELAY-1:0] hd_q;
  logic [W_DELAY-1:0] cnt;
  logic [W_SIZE-1:0]  col, row;
  logic [W_ADDR-1:0]  addr;
  logic               zero_q;
  logic               de_q;
  logic               last_q;
  logic               done_q;
  logic [W_PIX-1:0]   pix_hold;

  logic abort_req;
  logic abort_take;
  logic start_ok;
  logic zero_cfg;
  logic line_end;
  logic last_line;
  logic cnt_zero;
  logic rd_en;

`ifdef FRAME_READER_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Abort wins over a coincident start, and has no effect in IDLE.
  assign abort_take = abort_req && (state != S_IDLE);
  assign start_ok   = (state == S_IDLE) && i_start && !abort_req;
  assign zero_cfg   = (i_width == '0) || (i_height == '0);
  assign line_end   = (col == w_q - W_SIZE'(1));
  assign last_line  = (row == h_q - W_SIZE'(1));
  assign cnt_zero   = (cnt == '0);
  assign rd_en      = (state == S_LINE);

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (zero_cfg)                      state_d = S_FLUSH;
          else if (i_start_up_delay == '0)   state_d = S_LINE;
          else                               state_d = S_STARTUP;
        end
      end
      S_STARTUP: if (cnt_zero) state_d = S_LINE;
      S_LINE: begin
        if (line_end) begin
          if (last_line)            state_d = S_FLUSH;
          else if (hd_q == '0)      state_d = S_LINE;
          else                      state_d = S_HBLANK;
        end
      end
      S_HBLANK: if (cnt_zero) state_d = S_LINE;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_take) state_d = S_IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_d;
  end

  // Counters, latched configuration and the one-stage output pipeline
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      w_q    <= '0;
      h_q    <= '0;
      hd_q   <= '0;
      cnt    <= '0;
      col    <= '0;
      row    <= '0;
      addr   <= '0;
      zero_q <= 1'b0;
      de_q   <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort_take) begin
      // The read issued this cycle is dropped because de_q is cleared.
      cnt    <= '0;
      col    <= '0;
      row    <= '0;
      addr   <= '0;
      zero_q <= 1'b0;
      de_q   <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      de_q   <= rd_en;
      last_q <= rd_en && line_end && last_line;
      // An empty frame reports done right away; a real frame reports it on
      // leaving FLUSH, i.e. the cycle after its last beat.
      done_q <= (start_ok && zero_cfg) || ((state == S_FLUSH) && !zero_q);

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            w_q    <= i_width;
            h_q    <= i_height;
            hd_q   <= i_hsync_delay;
            cnt    <= i_start_up_delay - W_DELAY'(1);
            col    <= '0;
            row    <= '0;
            addr   <= '0;
            zero_q <= zero_cfg;
          end
        end
        S_STARTUP, S_HBLANK: begin
          if (!cnt_zero) cnt <= cnt - W_DELAY'(1);
        end
        S_LINE: begin
          addr <= addr + W_ADDR'(1);
          if (line_end) begin
            col <= '0;
            row <= row + W_SIZE'(1);
            cnt <= hd_q - W_DELAY'(1);
          end else begin
            col <= col + W_SIZE'(1);
          end
        end
        S_FLUSH: begin
          col <= '0;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

  // Holds the last delivered pixel so o_pixel is stable between beats.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)  pix_hold <= '0;
    else if (de_q) pix_hold <= i_rd_data;
  end

  assign o_rd_en      = rd_en;
  assign o_rd_addr    = addr;
  assign o_de         = de_q;
  // hsync is the read-side line strobe delayed like o_de, so it is the same bit.
  assign o_hsync      = de_q;
  // last_q keeps vsync high through the FLUSH cycle that carries the last beat.
  assign o_vsync      = (state == S_LINE) || (state == S_HBLANK) || last_q;
  assign o_pixel      = de_q ? i_rd_data : pix_hold;
  assign o_busy       = (state != S_IDLE);
  assign o_frame_done = done_q;
  assign o_dbg_state  = state;

endmodule
